// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/shift/logic, iterative shift-add multiply.
// Define ALU_DIV_EN to turn op 111 into an iterative restoring divide; otherwise it is illegal.
module alu_seq #(
   parameter int unsigned WIDTH        = 16,
   parameter bit          ARITH_RSHIFT = 1'b0
) (
   input  logic                 CLK100MHZ,
   input  logic                 CPU_RESETN,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   ans,
   output logic                 carry,
   output logic                 ovf,
   output logic                 zero,
   output logic                 err,
   output logic                 busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpRsh = 3'b011;
   localparam logic [2:0] OpLsh = 3'b100;
   localparam logic [2:0] OpAnd = 3'b101;
   localparam logic [2:0] OpOr  = 3'b110;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e               state_q, state_d;
   logic [SHW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   ans_q, ans_d;
   logic                 carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

   logic [WIDTH:0]       sum, diff, mul_sum;
   logic [WIDTH-1:0]     rsh, lsh;
   logic [SHW-1:0]       shamt;
   logic                 oversize;
   logic [2*WIDTH-1:0]   sc_ans, mul_step, step;
   logic                 sc_c, sc_v, sc_e;

`ifdef ALU_DIV_EN
   logic                 is_div_q, is_div_d, dz_q, dz_d;
   logic [WIDTH:0]       div_sh, div_sub;
   logic [2*WIDTH-1:0]   div_step;
`endif

   // Single-cycle results, computed straight from the request operands.
   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      shamt    = b[SHW-1:0];
      oversize = (b >= WIDTH'(WIDTH));
      if (oversize)          rsh = ARITH_RSHIFT ? {WIDTH{a[WIDTH-1]}} : '0;
      else if (ARITH_RSHIFT) rsh = $signed(a) >>> shamt;
      else                   rsh = a >> shamt;
      lsh    = oversize ? '0 : (a << shamt);
      sc_ans = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_e   = 1'b0;
      case (op)
         OpAdd: begin
            sc_ans = {{(WIDTH-1){1'b0}}, sum};
            sc_c   = sum[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            sc_ans = {{(WIDTH-1){diff[WIDTH]}}, diff};
            sc_c   = diff[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpRsh:   sc_ans = {{WIDTH{1'b0}}, rsh};
         OpLsh:   sc_ans = {{WIDTH{1'b0}}, lsh};
         OpAnd:   sc_ans = {{WIDTH{1'b0}}, a & b};
         OpOr:    sc_ans = {{WIDTH{1'b0}}, a | b};
         default: sc_e   = 1'b1;
      endcase
   end

   // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_sub  = div_sh - {1'b0, m_q};
      div_step = div_sub[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      step     = is_div_q ? div_step : mul_step;
`else
      step     = mul_step;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      acc_d   = acc_q;
      ans_d   = ans_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
`ifdef ALU_DIV_EN
      is_div_d = is_div_q;
      dz_d     = dz_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (op == OpMul) begin
                  state_d = StExec;
                  cnt_d   = '0;
                  m_d     = a;
                  acc_d   = {{WIDTH{1'b0}}, b};
`ifdef ALU_DIV_EN
                  is_div_d = 1'b0;
               end else if (op == 3'b111) begin
                  state_d  = StExec;
                  cnt_d    = '0;
                  m_d      = b;
                  acc_d    = {{WIDTH{1'b0}}, a};
                  is_div_d = 1'b1;
                  dz_d     = (b == '0);
`endif
               end else begin
                  state_d = StDone;
                  ans_d   = sc_ans;
                  carry_d = sc_c;
                  ovf_d   = sc_v;
                  err_d   = sc_e;
               end
            end
         end
         StExec: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDone;
               cnt_d   = '0;
               ans_d   = step;
               carry_d = 1'b0;
               ovf_d   = |step[2*WIDTH-1:WIDTH];
               err_d   = 1'b0;
`ifdef ALU_DIV_EN
               if (is_div_q) begin
                  ovf_d = 1'b0;
                  err_d = dz_q;
               end
`endif
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      zero_d = (ans_d == '0);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         ans_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_DIV_EN
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         ans_q   <= ans_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
`ifdef ALU_DIV_EN
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q == StExec);
   assign out_valid = (state_q == StDone);
   assign ans       = ans_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an arithmetic model.
module tb_alu_seq;

   localparam int W     = 16;
   localparam int W2    = 2 * W;
   localparam bit ARITH = 1'b0;

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic [W2-1:0] ans;
   logic          carry, ovf, zero, err, busy;

   int            n_vec, n_bad;
   logic [W2-1:0] last_ans;
   logic [3:0]    last_flags;

   typedef struct {
      logic [W2-1:0] ans;
      logic          c, v, z, e;
      int            lat;
   } exp_t;

   alu_seq #(.WIDTH(W), .ARITH_RSHIFT(ARITH)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ans       (ans),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero),
      .err       (err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      exp_t   r;
      longint full, lim, ux, uy, sx, sy, t;
      full = longint'(1) << W;
      lim  = longint'(1) << (W - 1);
      ux   = longint'(x);
      uy   = longint'(y);
      sx   = x[W-1] ? ux - full : ux;
      sy   = y[W-1] ? uy - full : uy;
      r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
      t = 0;
      case (o)
         3'd0: begin
            t = ux + uy;
            r.c = (t >= full);
            r.v = (sx + sy >= lim) || (sx + sy < -lim);
         end
         3'd1: begin
            t = ux - uy;
            r.c = (ux < uy);
            r.v = (sx - sy >= lim) || (sx - sy < -lim);
         end
         3'd2: begin
            t = ux * uy;
            r.v = (t >> W) != 0;
            r.lat = W + 1;
         end
         3'd3: begin
            if (ARITH) t = (uy >= W) ? ((sx < 0) ? -1 : 0) : (sx >>> uy);
            else       t = (uy >= W) ? 0 : (ux >> uy);
            t = t & (full - 1);
         end
         3'd4: t = (uy >= W) ? 0 : ((ux << uy) & (full - 1));
         3'd5: t = ux & uy;
         3'd6: t = ux | uy;
         default: begin
`ifdef ALU_DIV_EN
            r.lat = W + 1;
            if (uy == 0) begin
               t = (ux << W) | (full - 1);
               r.e = 1'b1;
            end else begin
               t = ((ux % uy) << W) | (ux / uy);
            end
`else
            t = 0;
            r.e = 1'b1;
`endif
         end
      endcase
      r.ans = W2'(t);
      r.z = (r.ans == '0);
      return r;
   endfunction

   // Issues one op from IDLE, checks latency, busy span, result and return to IDLE.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
      exp_t e;
      int   lat, bz;
      e = model(o, x, y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; bz = 0;
      while (!out_valid && lat < 200) begin
         if (busy) bz++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ":lat"}, 64'(lat), 64'(e.lat));
      chk({tag, ":busy"}, 64'(bz), 64'(e.lat - 1));
      chk({tag, ":ans"}, 64'(ans), 64'(e.ans));
      chk({tag, ":flags"}, 64'({carry, ovf, zero, err}), 64'({e.c, e.v, e.z, e.e}));
      last_ans   = ans;
      last_flags = {carry, ovf, zero, err};
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ":ret"}, 64'({in_ready, out_valid, busy}), 64'(3'b100));
   endtask

   initial begin
      logic [W2-1:0] s_ans;
      logic [3:0]    s_flags;
      logic [2:0]    ro;
      logic [W-1:0]  ra, rb;
      int            cyc;
      n_vec = 0; n_bad = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      #12;
      chk("reset:hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
      chk("reset:res", 64'({ans, carry, ovf, zero, err}), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(3'd0, 16'hFFFF, 16'h0001, "add_carry");
      chk("tp1", 64'({last_ans, last_flags}), 64'({32'h0001_0000, 4'b1000}));
      do_op(3'd1, 16'h0003, 16'h0005, "sub_neg");
      chk("tp2a", 64'({last_ans, last_flags[3:2]}), 64'({32'hFFFF_FFFE, 2'b10}));
      do_op(3'd1, 16'h8000, 16'h0001, "sub_ovf");
      chk("tp2b", 64'(last_flags[2]), 64'(1));
      do_op(3'd2, 16'h1234, 16'h5678, "mul");
      chk("tp3", 64'({last_ans, last_flags[2]}), 64'({32'h0626_0060, 1'b1}));
      do_op(3'd3, 16'h8000, 16'd4, "rsh");
      chk("tp4a", 64'(last_ans), ARITH ? 64'h0000_F800 : 64'h0000_0800);
      do_op(3'd4, 16'hABCD, 16'd16, "lsh16");
      chk("tp4b", 64'(last_ans), 64'(0));
      do_op(3'd5, 16'hF0F0, 16'h3C3C, "and");
      do_op(3'd6, 16'hF0F0, 16'h0F0F, "or");
      do_op(3'd7, 16'd100, 16'd7, "op7");
`ifdef ALU_DIV_EN
      chk("tp6a", 64'({last_ans, last_flags[0]}), 64'({32'h0002_000E, 1'b0}));
      do_op(3'd7, 16'd100, 16'd0, "div0");
      chk("tp6b", 64'({last_ans, last_flags[0]}), 64'({32'h0064_FFFF, 1'b1}));
`else
      chk("tp6", 64'({last_ans, last_flags[1:0]}), 64'({32'h0, 2'b11}));
`endif

      // Backpressure: result held while in_valid toggles in DONE.
      op = 3'd0; a = 16'h1234; b = 16'h0F0F; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("bp:valid", 64'(out_valid), 64'(1));
      s_ans = ans; s_flags = {carry, ovf, zero, err};
      chk("bp:ans0", 64'(s_ans), 64'(32'h0000_2143));
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid; op = 3'($urandom_range(0, 7)); a = W'($urandom);
         @(posedge clk); #1;
         chk("bp:hold", 64'({ans, carry, ovf, zero, err}), 64'({s_ans, s_flags}));
         chk("bp:hs", 64'({in_ready, out_valid}), 64'(2'b01));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp:idle", 64'({in_ready, out_valid, busy}), 64'(3'b100));
      @(posedge clk); #1;
      chk("bp:noacc", 64'({in_ready, out_valid, busy}), 64'(3'b100));

      // Asynchronous reset in the middle of a multiply.
      op = 3'd2; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst:hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
      chk("rst:ans", 64'({ans, carry, ovf, zero, err}), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst:ready", 64'(in_ready), 64'(1));
      do_op(3'd0, 16'd2, 16'd3, "post_rst");
      chk("rst:add", 64'(last_ans), 64'(5));

      for (int i = 0; i < 250; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = W'($urandom);
         rb = W'($urandom);
         if (ro == 3'd3 || ro == 3'd4) rb = W'($urandom_range(0, W + 3));
         if (ro == 3'd7 && $urandom_range(0, 5) == 0) rb = '0;
         if (ro == 3'd7 && $urandom_range(0, 1) == 0) rb = W'($urandom_range(1, 300));
         do_op(ro, ra, rb, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit switch-driven ALU on the Nexys board build.
- Accepts one operation at a time over a valid/ready input port.
- Executes single-cycle ops (add, sub, shifts, logic) directly; executes multiply (and optional divide) iteratively.
- Presents a registered 2*WIDTH result with status flags on a valid/ready output port, for a display or UART front end.

Parameters:
WIDTH, 16, operand width in bits; must be at least 4. Result width is 2*WIDTH. Shift-amount field width is SHW = clog2(WIDTH), a localparam.
ARITH_RSHIFT, 0, 1 = op RSHIFT fills with a[WIDTH-1]; 0 = fills with zeros.

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous, active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation
op  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 RSHIFT, 100 LSHIFT, 101 AND, 110 OR, 111 DIV/illegal
a  in  WIDTH  operand A
b  in  WIDTH  operand B; also the shift amount
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
ans  out  2*WIDTH  result
carry  out  1  carry/borrow
ovf  out  1  signed overflow (ADD/SUB); upper-half-nonzero (MUL)
zero  out  1  ans == 0
err  out  1  illegal op or divide-by-zero
busy  out  1  high in EXEC

Behaviour:
- Reset: CPU_RESETN is asynchronous and active-low; clock is CLK100MHZ. While low:
  - state forced to IDLE, iteration counter cleared.
  - ans, carry, ovf, zero, err, out_valid, busy all 0; in_ready = 1.
  - Reset mid-operation abandons the operation; no result is ever presented for it.
- FSM states IDLE, EXEC, DONE:
  - in_ready = (state == IDLE); busy = (state == EXEC); out_valid = (state == DONE).
  - IDLE: on in_valid, latch op, a and b.
    - Single-cycle ops go directly to DONE, so out_valid is high on the next edge (latency 1).
    - MUL, and DIV when enabled, go to EXEC with counter = 0.
  - EXEC: one shift-add iteration per cycle. After WIDTH iterations go to DONE. MUL latency is WIDTH+1 cycles from the accept edge to out_valid.
  - DONE: ans and flags are held stable until out_valid && out_ready, then go to IDLE.
  - in_valid is ignored outside IDLE. There is no accept in the same cycle as DONE → IDLE, so maximum throughput is one op per 2 cycles.
- Arithmetic (operands are unsigned unless noted):
  - ADD: {c,s} = a+b on WIDTH+1 bits. ans = zero-extended {c,s}; carry = c; ovf = signed overflow of s.
  - SUB: d = a-b on WIDTH+1 bits. ans = d sign-extended to 2*WIDTH; carry = borrow (a < b); ovf = signed overflow.
  - MUL: ans = a*b, unsigned full product. carry = 0; ovf = |ans[2W-1:W].
  - RSHIFT / LSHIFT: shift a by the full value of b. If b >= WIDTH the result is all fill bits. ans upper half = 0.
  - AND / OR: bitwise. ans upper half = 0.
- Flag rules:
  - carry and ovf are 0 for shifts and logic ops.
  - zero is computed over the whole of ans.
  - err is 0 except as defined for op 111.
- Flags are registered together with ans and change only on entry to DONE.

Optional Feature:
ALU_DIV_EN
- Defined: op 111 = unsigned restoring divide, WIDTH iterations in EXEC (latency WIDTH+1).
  - ans = {remainder, quotient}.
  - If b == 0: quotient = all ones, remainder = a, err = 1, same latency.
- Not defined: op 111 is illegal and completes with latency 1: ans = 0, zero = 1, err = 1. No divider logic is synthesised.

Test Plan:
1. ADD a=0xFFFF, b=0x0001 → one cycle after accept: out_valid=1, ans=0x00010000, carry=1, ovf=0, zero=0.
2. SUB a=0x0003, b=0x0005 → ans=0xFFFFFFFE, carry=1, ovf=0. Then SUB a=0x8000, b=0x0001 → ovf=1.
3. MUL a=0x1234, b=0x5678 → in_ready=0 and busy=1 for 16 cycles; out_valid exactly 17 cycles after accept; ans=0x06260060, ovf=1.
4. RSHIFT a=0x8000, b=4 → ans=0x00000800 (ARITH_RSHIFT=0) or 0x0000F800 (ARITH_RSHIFT=1). LSHIFT with b=16 → ans=0.
5. Backpressure plus reset:
   - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid → ans and flags stable, nothing accepted.
   - Raise out_ready → IDLE next cycle.
   - Pull CPU_RESETN low asynchronously at MUL iteration 8 → out_valid=0 immediately, in_ready=1 after release, next ADD 2+3 gives ans=5.
6. Op 111, a=100, b=7:
   - With ALU_DIV_EN: ans=0x0002000E, err=0. With b=0: ans=0x0064FFFF, err=1.
   - Without ALU_DIV_EN: latency 1, ans=0, zero=1, err=1.
